// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: ALU control codes, funct and ALUOp
// encodings, and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_MULT = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_AND   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct lookup. DIV (funct 0x1A) is only recognised when
// ALUCTRL_DIV_EN is defined; otherwise it falls into the illegal default.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  output logic [3:0]         code,
  output logic               illegal,
  output logic               is_multi,
  output logic               lat_sel
);

  logic op_high;

  // ALUOp encodings wider than two bits with any upper bit set are unsupported.
  if (ALUOP_W > 2) begin : g_wide_op
    assign op_high = |alu_op[ALUOP_W-1:2];
  end else begin : g_narrow_op
    assign op_high = 1'b0;
  end

  always_comb begin
    code     = ALU_ADD;
    illegal  = 1'b0;
    is_multi = 1'b0;
    lat_sel  = 1'b0;
    if (op_high) begin
      illegal = 1'b1;
    end else begin
      case (alu_op[1:0])
        OP_ADD: code = ALU_ADD;
        OP_SUB: code = ALU_SUB;
        OP_AND: code = ALU_AND;
        OP_RTYPE: begin
          case (funct)
            F_ADD:  code = ALU_ADD;
            F_SUB:  code = ALU_SUB;
            F_AND:  code = ALU_AND;
            F_OR:   code = ALU_OR;
            F_SLT:  code = ALU_SLT;
            F_XOR:  code = ALU_XOR;
            F_NOR:  code = ALU_NOR;
            F_SLL:  code = ALU_SLL;
            F_SRL:  code = ALU_SRL;
            F_MULT: begin
              code     = ALU_MULT;
              is_multi = 1'b1;
            end
`ifdef ALUCTRL_DIV_EN
            F_DIV: begin
              code     = ALU_DIV;
              is_multi = 1'b1;
              lat_sel  = 1'b1;
            end
`endif
            default: illegal = 1'b1;
          endcase
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit for the EX stage with mult/div sequencing.
// Optional macro ALUCTRL_DIV_EN enables the multi-cycle DIV operation.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic               stall_in,
  input  logic               flush,
  output logic               in_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic               valid_out,
  output logic               illegal_op,
  output logic               multi_start,
  output logic               stall_req
);

  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_ctrl_seq: CTRL_W must be at least 4");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("alu_ctrl_seq: MUL_LAT and DIV_LAT must be at least 1");
  end

`ifdef ALUCTRL_DIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
  localparam int MAX_LAT = MUL_LAT;
`endif
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
`ifdef ALUCTRL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
`else
  localparam logic [CNT_W-1:0] DIV_LOAD = MUL_LOAD;
`endif

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CTRL_W-1:0] ctrl_next;
  logic              valid_next, illegal_next, start_next, stall_next;
  logic [3:0]        dec_code;
  logic              dec_illegal, dec_multi, dec_lat_sel;
  logic              accept;

  alu_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .code     (dec_code),
    .illegal  (dec_illegal),
    .is_multi (dec_multi),
    .lat_sel  (dec_lat_sel)
  );

  assign in_ready = (state == IDLE);
  assign accept   = valid_in & in_ready & ~stall_in & ~flush;

  // Flush beats everything but reset; in BUSY the counter runs regardless of stall_in.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ctrl_next    = ctrl_out;
    valid_next   = valid_out;
    illegal_next = illegal_op;
    start_next   = 1'b0;
    stall_next   = stall_req;
    if (flush) begin
      state_next   = IDLE;
      cnt_next     = '0;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
      stall_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_next    = CTRL_W'(dec_code);
            valid_next   = 1'b1;
            illegal_next = dec_illegal;
            if (dec_multi) begin
              start_next = 1'b1;
              stall_next = 1'b1;
              cnt_next   = dec_lat_sel ? DIV_LOAD : MUL_LOAD;
              state_next = BUSY;
            end
          end else if (!stall_in) begin
            valid_next = 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state_next = IDLE;
            stall_next = 1'b0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ctrl_out    <= '0;
      valid_out   <= 1'b0;
      illegal_op  <= 1'b0;
      multi_start <= 1'b0;
      stall_req   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ctrl_out    <= ctrl_next;
      valid_out   <= valid_next;
      illegal_op  <= illegal_next;
      multi_start <= start_next;
      stall_req   <= stall_next;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized traffic
// against a cycle-level behavioural model. Honours ALUCTRL_DIV_EN like the design.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT_TB = 4;
  localparam int DIV_LAT_TB = 16;

  logic       clk = 1'b0;
  logic       reset, valid_in, stall_in, flush;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       in_ready, valid_out, illegal_op, multi_start, stall_req;
  logic [3:0] ctrl_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: busy_left counts stall cycles still owed by a mult/div.
  logic [3:0] m_ctrl = 4'd0;
  logic       m_valid = 1'b0, m_ill = 1'b0, m_start = 1'b0, m_stall = 1'b0;
  int         m_busy = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .ALUOP_W(2), .CTRL_W(4), .MUL_LAT(MUL_LAT_TB), .DIV_LAT(DIV_LAT_TB)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op), .funct(funct),
    .stall_in(stall_in), .flush(flush), .in_ready(in_ready), .ctrl_out(ctrl_out),
    .valid_out(valid_out), .illegal_op(illegal_op), .multi_start(multi_start),
    .stall_req(stall_req)
  );

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] code, output logic ill,
                                     output int lat);
    code = 4'd2;
    ill  = 1'b0;
    lat  = 0;
    case (op)
      2'b00: code = 4'd2;
      2'b01: code = 4'd6;
      2'b11: code = 4'd0;
      default: begin
        case (f)
          6'h20: code = 4'd2;
          6'h22: code = 4'd6;
          6'h24: code = 4'd0;
          6'h25: code = 4'd1;
          6'h2A: code = 4'd7;
          6'h26: code = 4'd3;
          6'h27: code = 4'd12;
          6'h00: code = 4'd8;
          6'h02: code = 4'd9;
          6'h18: begin code = 4'd10; lat = MUL_LAT_TB; end
`ifdef ALUCTRL_DIV_EN
          6'h1A: begin code = 4'd11; lat = DIV_LAT_TB; end
`endif
          default: ill = 1'b1;
        endcase
      end
    endcase
  endfunction

  function automatic void model_step();
    logic [3:0] code;
    logic       ill;
    int         lat;
    m_start = 1'b0;
    if (reset) begin
      m_ctrl = 4'd0; m_valid = 1'b0; m_ill = 1'b0; m_stall = 1'b0; m_busy = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_ill = 1'b0; m_stall = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy  = m_busy - 1;
      m_stall = (m_busy > 0);
    end else if (valid_in && !stall_in) begin
      ref_decode(alu_op, funct, code, ill, lat);
      m_ctrl  = code;
      m_valid = 1'b1;
      m_ill   = ill;
      if (lat > 0) begin
        m_start = 1'b1;
        m_stall = 1'b1;
        m_busy  = lat;
      end
    end else if (!stall_in) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    valid_in = 1'b0; stall_in = 1'b0; flush = 1'b0; alu_op = 2'b00; funct = 6'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    cycle();
    cycle();
    checks++;
    if ({ctrl_out, valid_out, illegal_op, multi_start, stall_req, in_ready} !== 9'b0000_0000_1) begin
      errors++;
      $display("[TB] FAIL reset_state: got ctrl=%0d valid=%b ill=%b start=%b stall=%b ready=%b, want 0 0 0 0 0 1",
               ctrl_out, valid_out, illegal_op, multi_start, stall_req, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_or();
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h25;
    cycle();
    valid_in = 1'b0;
    checks++;
    if (ctrl_out !== 4'd1 || valid_out !== 1'b1 || illegal_op !== 1'b0) begin
      errors++;
      $display("[TB] FAIL or_decode: got ctrl=%0d valid=%b ill=%b, want ctrl=1 valid=1 ill=0",
               ctrl_out, valid_out, illegal_op);
    end
    cycle();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_valid_clear: got valid=%b, want 0", valid_out);
    end
  endtask

  task automatic test_mult();
    int stall_cycles = 0;
    int starts = 0;
    int ready_bad = 0;
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h18;
    cycle();
    checks++;
    if (ctrl_out !== 4'd10 || multi_start !== 1'b1 || stall_req !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_accept: got ctrl=%0d start=%b stall=%b ready=%b, want 10 1 1 0",
               ctrl_out, multi_start, stall_req, in_ready);
    end
    // A request offered while busy must be ignored.
    alu_op = 2'b01; funct = 6'h00;
    for (int i = 0; i < 40; i++) begin
      if (stall_req !== 1'b1) break;
      stall_cycles++;
      if (multi_start === 1'b1) starts++;
      if (in_ready !== 1'b0) ready_bad++;
      cycle();
    end
    valid_in = 1'b0;
    checks++;
    if (stall_cycles != MUL_LAT_TB) begin
      errors++;
      $display("[TB] FAIL mult_stall_len: got %0d cycles, want %0d", stall_cycles, MUL_LAT_TB);
    end
    checks++;
    if (starts != 1) begin
      errors++;
      $display("[TB] FAIL mult_start_pulse: got %0d pulses, want 1", starts);
    end
    checks++;
    if (ready_bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mult_ready: got %0d busy-ready cycles, final ready=%b, want 0 and 1",
               ready_bad, in_ready);
    end
    checks++;
    if (ctrl_out !== 4'd10 || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_ignore: got ctrl=%0d valid=%b, want ctrl=10 valid=1", ctrl_out, valid_out);
    end
    cycle();
  endtask

  task automatic test_illegal();
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h3F;
    cycle();
    valid_in = 1'b0;
    checks++;
    if (ctrl_out !== 4'd2 || illegal_op !== 1'b1 || stall_req !== 1'b0 || multi_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_funct: got ctrl=%0d ill=%b stall=%b start=%b, want 2 1 0 0",
               ctrl_out, illegal_op, stall_req, multi_start);
    end
    cycle();
  endtask

  task automatic test_stall();
    valid_in = 1'b1; alu_op = 2'b11; funct = 6'h00;
    cycle();
    stall_in = 1'b1; alu_op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ctrl_out !== 4'd0 || valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got ctrl=%0d valid=%b, want ctrl=0 valid=1", i, ctrl_out, valid_out);
      end
    end
    stall_in = 1'b0;
    cycle();
    valid_in = 1'b0;
    checks++;
    if (ctrl_out !== 4'd6 || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: got ctrl=%0d valid=%b, want ctrl=6 valid=1", ctrl_out, valid_out);
    end
    cycle();
  endtask

`ifdef ALUCTRL_DIV_EN
  task automatic test_div();
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h1A;
    cycle();
    valid_in = 1'b0;
    checks++;
    if (ctrl_out !== 4'd11 || multi_start !== 1'b1 || stall_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_accept: got ctrl=%0d start=%b stall=%b, want 11 1 1", ctrl_out, multi_start, stall_req);
    end
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (stall_req !== 1'b0 || valid_out !== 1'b0 || in_ready !== 1'b1 || illegal_op !== 1'b0 || ctrl_out !== 4'd11) begin
      errors++;
      $display("[TB] FAIL div_flush: got stall=%b valid=%b ready=%b ill=%b ctrl=%0d, want 0 0 1 0 11",
               stall_req, valid_out, in_ready, illegal_op, ctrl_out);
    end
  endtask
`else
  task automatic test_div();
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'h1A;
    cycle();
    valid_in = 1'b0;
    checks++;
    if (illegal_op !== 1'b1 || multi_start !== 1'b0 || stall_req !== 1'b0 || ctrl_out !== 4'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_disabled: got ill=%b start=%b stall=%b ctrl=%0d ready=%b, want 1 0 0 2 1",
               illegal_op, multi_start, stall_req, ctrl_out, in_ready);
    end
    cycle();
  endtask
`endif

  task automatic test_back_to_back();
    logic [5:0] f_list[4] = '{6'h2A, 6'h27, 6'h00, 6'h02};
    logic [3:0] e_list[4] = '{4'd7, 4'd12, 4'd8, 4'd9};
    valid_in = 1'b1; alu_op = 2'b10;
    for (int i = 0; i < 4; i++) begin
      funct = f_list[i];
      cycle();
      checks++;
      if (ctrl_out !== e_list[i] || valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got ctrl=%0d valid=%b, want ctrl=%0d valid=1",
                 i, ctrl_out, valid_out, e_list[i]);
      end
    end
    valid_in = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [5:0] pool[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27,
                             6'h00, 6'h02, 6'h18, 6'h1A, 6'h3F};
    logic [8:0] exp_v, act_v;
    for (int n = 0; n < 600; n++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      alu_op   = 2'($urandom_range(0, 3));
      funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      reset    = ($urandom_range(0, 149) == 0);
      cycle();
      exp_v = {m_ctrl, m_valid, m_ill, m_start, m_stall, (m_busy == 0)};
      act_v = {ctrl_out, valid_out, illegal_op, multi_start, stall_req, in_ready};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL random[%0d] {ctrl,valid,ill,start,stall,ready}: got %h, want %h", n, act_v, exp_v);
      end
    end
    reset = 1'b0;
    set_idle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_or();
    test_mult();
    test_illegal();
    test_stall();
    test_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
